clk_gate_ctrl: RTL and testbench



---
 rtl/clk_gate_ctrl.sv | 131 +++++++++++++
 tb/tb_clk_gate_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - shared clock-enable controller with wake latency and idle hold-off (option: CLK_GATE_CTRL_STATS_EN)
module clk_gate_ctrl #(
    parameter int NUM_REQ     = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 8,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] ack_o,
    output logic               clk_en_o,
    output logic               busy_o,
    output logic [1:0]         state_o
`ifdef CLK_GATE_CTRL_STATS_EN
    ,
    input  logic               stats_clr_i,
    output logic [CNT_W-1:0]   gated_cycles_o
`endif
);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_WAKE = 2'd1,
        S_ON   = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
    localparam bit               IDLE_ZERO = (IDLE_CYCLES == 0);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_clk_en;
    logic               r_busy;
    logic [NUM_REQ-1:0] r_ack;
    logic               w_any;

    assign w_any = |req_i;

    // Controller FSM: enable, acks, busy and the shared wake/idle counter are all registered here
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_OFF;
            r_cnt    <= '0;
            r_clk_en <= 1'b0;
            r_busy   <= 1'b0;
            r_ack    <= '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    r_ack <= '0;
                    if (w_any) begin
                        r_state  <= S_WAKE;
                        r_cnt    <= WAKE_LOAD;
                        r_clk_en <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_WAKE: begin
                    // wake always runs to completion, even if every request has dropped
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_any) begin
                        r_state <= S_ON;
                        r_ack   <= req_i;
                    end else if (IDLE_ZERO) begin
                        r_state  <= S_OFF;
                        r_clk_en <= 1'b0;
                        r_busy   <= 1'b0;
                    end else begin
                        r_state <= S_HOLD;
                        r_cnt   <= IDLE_LOAD;
                    end
                end
                S_ON: begin
                    if (w_any) begin
                        r_ack <= req_i;
                    end else begin
                        r_ack <= '0;
                        if (IDLE_ZERO) begin
                            r_state  <= S_OFF;
                            r_clk_en <= 1'b0;
                            r_busy   <= 1'b0;
                        end else begin
                            r_state <= S_HOLD;
                            r_cnt   <= IDLE_LOAD;
                        end
                    end
                end
                default: begin
                    // HOLD: clock still running, so a new request re-acks without wake latency
                    if (w_any) begin
                        r_state <= S_ON;
                        r_ack   <= req_i;
                    end else if (r_cnt == '0) begin
                        r_state  <= S_OFF;
                        r_clk_en <= 1'b0;
                        r_busy   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign ack_o    = r_ack;
    assign clk_en_o = r_clk_en;
    assign busy_o   = r_busy;
    assign state_o  = r_state;

`ifdef CLK_GATE_CTRL_STATS_EN
    logic [CNT_W-1:0] r_gated;

    // Saturating count of edges with the clock gated; clear beats increment
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_gated <= '0;
        end else if (stats_clr_i) begin
            r_gated <= '0;
        end else if (!r_clk_en && (r_gated != {CNT_W{1'b1}})) begin
            r_gated <= r_gated + 1'b1;
        end
    end

    assign gated_cycles_o = r_gated;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - directed scoreboard bench for clk_gate_ctrl
module tb_clk_gate_ctrl;

    localparam logic [1:0] OFF  = 2'd0;
    localparam logic [1:0] WAKE = 2'd1;
    localparam logic [1:0] ON   = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req_i;
    logic [3:0] ack_o;
    logic       clk_en_o;
    logic       busy_o;
    logic [1:0] state_o;
    logic [3:0] req0;
    logic [3:0] ack0;
    logic       clk_en0;
    logic       busy0;
    logic [1:0] state0;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

`ifdef CLK_GATE_CTRL_STATS_EN
    logic        stats_clr;
    logic [15:0] gated_cycles;
    logic [15:0] gated0;
    logic [3:0]  gated_s4;
    logic [3:0]  ack_s4;
    logic        clk_en_s4;
    logic        busy_s4;
    logic [1:0]  state_s4;
`endif

    clk_gate_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_i          (req_i),
        .ack_o          (ack_o),
        .clk_en_o       (clk_en_o),
        .busy_o         (busy_o),
        .state_o        (state_o)
`ifdef CLK_GATE_CTRL_STATS_EN
        ,
        .stats_clr_i    (stats_clr),
        .gated_cycles_o (gated_cycles)
`endif
    );

    clk_gate_ctrl #(.IDLE_CYCLES(0)) dut0 (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_i          (req0),
        .ack_o          (ack0),
        .clk_en_o       (clk_en0),
        .busy_o         (busy0),
        .state_o        (state0)
`ifdef CLK_GATE_CTRL_STATS_EN
        ,
        .stats_clr_i    (stats_clr),
        .gated_cycles_o (gated0)
`endif
    );

`ifdef CLK_GATE_CTRL_STATS_EN
    clk_gate_ctrl #(.CNT_W(4)) dut_s4 (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_i          (4'b0000),
        .ack_o          (ack_s4),
        .clk_en_o       (clk_en_s4),
        .busy_o         (busy_s4),
        .state_o        (state_s4),
        .stats_clr_i    (stats_clr),
        .gated_cycles_o (gated_s4)
    );
`endif

    // one edge of the default instance: push expectation, clock, pop and compare
    task automatic cyc(input logic [3:0] req, input logic [1:0] es, input logic een,
                       input logic [3:0] eack, input string tag);
        logic [7:0] obs;
        logic [7:0] exp;
        req_i = req;
        exp_q.push_back({es, een, eack, (es != OFF)});
        @(posedge clk);
        #1;
        obs = {state_o, clk_en_o, ack_o, busy_o};
        exp = exp_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one edge of the IDLE_CYCLES=0 instance
    task automatic cyc0(input logic [3:0] req, input logic [1:0] es, input logic een,
                        input logic [3:0] eack, input string tag);
        logic [7:0] obs;
        logic [7:0] exp;
        req0 = req;
        exp_q.push_back({es, een, eack, (es != OFF)});
        @(posedge clk);
        #1;
        obs = {state0, clk_en0, ack0, busy0};
        exp = exp_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input logic [15:0] obs, input logic [15:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req_i   = '0;
        req0    = '0;
`ifdef CLK_GATE_CTRL_STATS_EN
        stats_clr = 1'b0;
`endif
        @(posedge clk);
        #1;
        cyc(4'b0000, OFF, 1'b0, 4'b0000, "reset_state");
        cyc0(4'b0000, OFF, 1'b0, 4'b0000, "reset_state_idle0");
        reset_n = 1'b1;

`ifdef CLK_GATE_CTRL_STATS_EN
        chk_val(gated_cycles, 16'd0, "stats_reset");
        for (int i = 0; i < 10; i++) cyc(4'b0000, OFF, 1'b0, 4'b0000, "idle_off");
        chk_val(gated_cycles, 16'd10, "stats_10");
        for (int i = 0; i < 10; i++) cyc(4'b0000, OFF, 1'b0, 4'b0000, "idle_off");
        chk_val(gated_cycles, 16'd20, "stats_20");
        chk_val({12'd0, gated_s4}, 16'd15, "stats_saturate");
        stats_clr = 1'b1;
        cyc(4'b0000, OFF, 1'b0, 4'b0000, "idle_clr");
        stats_clr = 1'b0;
        chk_val(gated_cycles, 16'd0, "stats_clear");
        chk_val({12'd0, gated_s4}, 16'd0, "stats_clear_s4");
        cyc(4'b0000, OFF, 1'b0, 4'b0000, "idle_after_clr");
        chk_val(gated_cycles, 16'd1, "stats_after_clr");
`endif

        // wake latency
        cyc(4'b0001, WAKE, 1'b1, 4'b0000, "wake_e1");
        cyc(4'b0001, WAKE, 1'b1, 4'b0000, "wake_e2");
        cyc(4'b0001, ON,   1'b1, 4'b0001, "wake_on");

        // multi-requester in ON
        cyc(4'b0011, ON, 1'b1, 4'b0011, "multi_0011");
        cyc(4'b0010, ON, 1'b1, 4'b0010, "multi_0010");
        cyc(4'b1010, ON, 1'b1, 4'b1010, "multi_1010");

        // idle hold-off: HOLD for edges N..N+7, OFF after N+8
        for (int i = 0; i < 8; i++) cyc(4'b0000, HOLD, 1'b1, 4'b0000, "holdoff");
        cyc(4'b0000, OFF, 1'b0, 4'b0000, "holdoff_off");

        // HOLD re-request on the 4th HOLD cycle
        cyc(4'b0100, WAKE, 1'b1, 4'b0000, "rewake_e1");
        cyc(4'b0100, WAKE, 1'b1, 4'b0000, "rewake_e2");
        cyc(4'b0100, ON,   1'b1, 4'b0100, "rewake_on");
        for (int i = 0; i < 4; i++) cyc(4'b0000, HOLD, 1'b1, 4'b0000, "hold_short");
        cyc(4'b0100, ON, 1'b1, 4'b0100, "hold_rereq");

        // request on the exact edge HOLD would expire
        for (int i = 0; i < 8; i++) cyc(4'b0000, HOLD, 1'b1, 4'b0000, "hold_full");
        cyc(4'b0001, ON, 1'b1, 4'b0001, "hold_expiry_on");

        // reset mid-operation in ON, then in WAKE
        reset_n = 1'b0;
        cyc(4'b0001, OFF, 1'b0, 4'b0000, "rst_in_on");
        reset_n = 1'b1;
        cyc(4'b0001, WAKE, 1'b1, 4'b0000, "rst_rewake");
        reset_n = 1'b0;
        cyc(4'b0001, OFF, 1'b0, 4'b0000, "rst_in_wake");
        reset_n = 1'b1;
        cyc(4'b0001, WAKE, 1'b1, 4'b0000, "rst_rewake2");

        // request drop during WAKE does not abort it; expiry then goes to HOLD
        cyc(4'b0000, WAKE, 1'b1, 4'b0000, "wake_drop");
        cyc(4'b0000, HOLD, 1'b1, 4'b0000, "wake_to_hold");
        for (int i = 0; i < 7; i++) cyc(4'b0000, HOLD, 1'b1, 4'b0000, "wake_hold");
        cyc(4'b0000, OFF, 1'b0, 4'b0000, "wake_hold_off");

        // IDLE_CYCLES=0 instance: direct OFF from ON and from WAKE
        cyc0(4'b0010, WAKE, 1'b1, 4'b0000, "i0_wake1");
        cyc0(4'b0010, WAKE, 1'b1, 4'b0000, "i0_wake2");
        cyc0(4'b0010, ON,   1'b1, 4'b0010, "i0_on");
        cyc0(4'b0000, OFF,  1'b0, 4'b0000, "i0_off_from_on");
        cyc0(4'b1000, WAKE, 1'b1, 4'b0000, "i0_wake3");
        cyc0(4'b0000, WAKE, 1'b1, 4'b0000, "i0_wake_drop");
        cyc0(4'b0000, OFF,  1'b0, 4'b0000, "i0_off_from_wake");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
